uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer between the UART Rx engine datapath and the host/TSI read port. It captures each completed frame (data byte plus parity and framing error flags) when the Rx datapath raises `rx_rdy`, and returns the `reads` acknowledge that clears `rx_rdy`. It queues frames in a first-word-fall-through FIFO so the host can drain them at its own pace. This decouples host read latency from the serial line rate and absorbs bursts of up to `DEPTH` frames before the Rx datapath reports overflow.

## Interface
- `DEPTH`, 16, number of FIFO entries; power of two, 2..256.
- `AW`, $clog2(DEPTH), pointer width; derived, not overridden.
- `clk`  input  1  system clock, same domain as the Rx engine.
- `rst`  input  1  asynchronous, active-low reset.
- `rx_rdy`  input  1  level from Rx datapath; high while a received frame is held.
- `rx_data`  input  8  received byte; bit 7 is already zero in 7-bit mode.
- `parity_err`  input  1  parity error for the held frame.
- `frame_err`  input  1  framing error for the held frame.
- `reads`  output  1  one-cycle acknowledge to Rx datapath; clears its `rx_rdy`.
- `rd`  input  1  host pop strobe, sampled on `clk`.
- `rd_data`  output  8  head entry byte; 8'h00 when empty.
- `rd_pe`, `rd_fe`  output  1 each  head entry error flags; 0 when empty.
- `empty`, `full`  output  1 each  registered FIFO status.
- `count`  output  AW+1  entries held, 0..DEPTH.
- `ovf`  output  1  sticky: a frame was pending while the FIFO was full.
- `ovf_clr`  input  1  clears `ovf`.

## Operation
- Storage is a `DEPTH` x 10-bit array holding {fe, pe, data[7:0]}. Read and write pointers are AW bits and wrap modulo `DEPTH`. `count` is held separately.
- The write-side FSM has two states, IDLE and WAIT:
  - IDLE with `rx_rdy`=1 and `full`=0: write the entry at wptr, increment wptr, pulse `reads`, go to WAIT.
  - IDLE with `rx_rdy`=1 and `full`=1: no write and no `reads`. Set `ovf`. Stay in IDLE, so the frame is retried each cycle until space frees.
  - WAIT: stay until `rx_rdy`=0, then go to IDLE. This guarantees exactly one capture per frame even if `rx_rdy` falls late.
- Read side: `rd`=1 with `empty`=0 increments rptr. `rd` while empty is ignored, with no pointer or count change.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- `full` = (count==DEPTH) and `empty` = (count==0), both registered from next-state count.
- `ovf`: a set and `ovf_clr` in the same cycle leaves `ovf`=1 (set wins).

## Timing
- Reset (asynchronous assert): pointers=0, `count`=0, `empty`=1, `full`=0, `reads`=0, `ovf`=0, FSM=IDLE. Memory contents are not reset. Any frame in progress is dropped, and WAIT is abandoned.
- The FSM leaves reset in IDLE. If `rx_rdy` is already high on the first cycle, that frame is captured.
- Latency, capture path: `rx_rdy` sampled high in IDLE, then the entry is written and `reads`=1 on the next clock edge.
- Latency, host path: after a push, `empty` falls one cycle later, and `rd_data` is valid in the same cycle (first-word fall-through, combinational from mem[rptr]).
- Full with a simultaneous pop: `full` is registered, so the stalled frame is written one cycle after the pop.
- Pointer wrap: entry DEPTH-1 followed by entry 0 must preserve order.

## Configuration
- `UART_RX_FIFO_THRESH_EN` defined:
  - adds input `thresh` (AW+1 bits) and output `rx_irq` (1 bit, registered).
  - `rx_irq`=1 when `count` >= `thresh` and `thresh` != 0; it resets to 0.
- Not defined: neither port exists, and the host polls `empty`.

## Structure
- The shared UART package holds the entry field positions (DATA_LSB=0, PE_BIT=8, FE_BIT=9), the entry width constant 10, and the FSM state encoding (IDLE=1'b0, WAIT=1'b1).
- One sub-module, `uart_fifo_mem`: a parameterised DEPTH x WIDTH register array with synchronous write and asynchronous read, and no reset. All pointer, count and FSM logic stays in `uart_rx_fifo`.

## Test plan
- Reset, then push 0x41 with pe=0, fe=0: `reads` pulses once, then `empty`=0, `count`=1, `rd_data`=0x41. Pulse `rd`: `empty`=1, `rd_data`=0x00.
- Hold `rx_rdy` high for 10 cycles after `reads`: exactly one entry is written, `count`=1.
- Push 16 frames 0x00..0x0F, then present 0x10: `full`=1, no `reads`, `ovf`=1. Pop once: 0x10 is written the following cycle, `count`=16, and pops return 0x01..0x10 in order across the wrap.
- Simultaneous push and `rd` at `count`=5: `count` stays 5, and the head advances to the next entry.
- Frame 0x7E with pe=1, fe=1: `rd_pe`=1, `rd_fe`=1. Assert `ovf_clr` together with a new overflow event: `ovf` stays 1.
- Assert `rst` in WAIT with `count`=3: `count`=0 and the FSM is in IDLE immediately. With `UART_RX_FIFO_THRESH_EN` defined and `thresh`=4, `rx_irq` rises on the 4th push.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-side definitions: FIFO entry layout and write-side FSM encoding.
package uart_rx_fifo_pkg;
  localparam int ENTRY_W  = 10;
  localparam int DATA_LSB = 0;
  localparam int PE_BIT   = 8;
  localparam int FE_BIT   = 9;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rx_state_e;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 10,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Rx frame capture + first-word-fall-through FIFO toward the host read port.
// Optional UART_RX_FIFO_THRESH_EN adds a count threshold interrupt (thresh / rx_irq).
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  input  logic          parity_err,
  input  logic          frame_err,
  output logic          reads,
  input  logic          rd,
  output logic [7:0]    rd_data,
  output logic          rd_pe,
  output logic          rd_fe,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  input  logic [AW:0]   thresh,
  output logic          rx_irq
`endif
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rx_state_e          state_q, state_d;
  logic [AW-1:0]      wptr, rptr;
  logic [AW:0]        count_d;
  logic [ENTRY_W-1:0] wentry, rentry;
  logic               push, pop, ovf_set;

  // WAIT holds off a second capture until the datapath drops rx_rdy.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: if (rx_rdy) begin
        if (!full) begin
          push    = 1'b1;
          state_d = WAIT;
        end else begin
          ovf_set = 1'b1;
        end
      end
      WAIT:    if (!rx_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pop = rd & ~empty;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_comb begin
    wentry                  = '0;
    wentry[DATA_LSB +: 8]   = rx_data;
    wentry[PE_BIT]          = parity_err;
    wentry[FE_BIT]          = frame_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      reads   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count   <= count_d;
      empty   <= (count_d == '0);
      full    <= (count_d == FULL_CNT);
      reads   <= push;
      // A pending frame on a full FIFO outranks a clear.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_irq <= 1'b0;
    else      rx_irq <= (thresh != '0) && (count_d >= thresh);
  end
`endif

  uart_fifo_mem #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wentry),
    .raddr (rptr),
    .rdata (rentry)
  );

  assign rd_data = empty ? 8'h00 : rentry[DATA_LSB +: 8];
  assign rd_pe   = ~empty & rentry[PE_BIT];
  assign rd_fe   = ~empty & rentry[FE_BIT];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: Rx datapath model, host pops checked against a scoreboard queue.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          rx_rdy = 1'b0, parity_err = 1'b0, frame_err = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rd = 1'b0, ovf_clr = 1'b0;
  logic          reads, rd_pe, rd_fe, empty, full, ovf;
  logic [7:0]    rd_data;
  logic [AW:0]   count;
`ifdef UART_RX_FIFO_THRESH_EN
  logic [AW:0]   thresh = '0;
  logic          rx_irq;
`endif

  int n_chk = 0, n_fail = 0, nreads = 0, nr0 = 0;
  logic [9:0] sb [$];

  typedef struct {
    bit         push;
    bit         pop;
    logic [7:0] d;
    bit         pe;
    bit         fe;
    int         exp_count;
  } vec_t;
  vec_t vt [12];

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .parity_err(parity_err), .frame_err(frame_err), .reads(reads),
    .rd(rd), .rd_data(rd_data), .rd_pe(rd_pe), .rd_fe(rd_fe),
    .empty(empty), .full(full), .count(count), .ovf(ovf), .ovf_clr(ovf_clr)
`ifdef UART_RX_FIFO_THRESH_EN
    , .thresh(thresh), .rx_irq(rx_irq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reads === 1'b1) nreads++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a frame, wait (bounded) for reads, optionally hold rx_rdy, then release.
  task automatic send(input logic [7:0] d, input bit pe, input bit fe, input int hold = 0);
    bit got = 0;
    rx_data = d; parity_err = pe; frame_err = fe; rx_rdy = 1'b1;
    sb.push_back({fe, pe, d});
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (reads === 1'b1) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: got no reads expected reads for %0h", d);
    end
    cyc(hold);
    rx_rdy = 1'b0;
    cyc();
  endtask

  task automatic check_head(input string name);
    logic [9:0] e;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_data"}, 32'(rd_data), 32'(e[7:0]));
      chk({name, "_pe"},   32'(rd_pe),   32'(e[8]));
      chk({name, "_fe"},   32'(rd_fe),   32'(e[9]));
    end
  endtask

  task automatic pop(input string name);
    check_head(name);
    rd = 1'b1; cyc(); rd = 1'b0;
  endtask

  // Push and pop on the same edge.
  task automatic both(input logic [7:0] d, input bit pe, input bit fe);
    check_head("both");
    sb.push_back({fe, pe, d});
    rx_data = d; parity_err = pe; frame_err = fe; rx_rdy = 1'b1; rd = 1'b1;
    cyc();
    chk("both_reads", 32'(reads), 32'd1);
    rd = 1'b0; rx_rdy = 1'b0;
    cyc();
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1};
    vt[1]  = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 2};
    vt[2]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 3};
    vt[3]  = '{1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 4};
    vt[4]  = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 5};
    vt[5]  = '{1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 5};
    vt[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4};
    vt[7]  = '{1'b1, 1'b0, 8'h7E, 1'b1, 1'b1, 5};
    vt[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4};
    vt[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3};
    vt[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2};
    vt[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1};

    // Reset state
    cyc(2);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_reads", 32'(reads), 32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_rdata", 32'(rd_data), 32'h00);
    rst = 1'b1;
    cyc();

    // Pop while empty is ignored
    rd = 1'b1; cyc(); rd = 1'b0;
    chk("empty_rd_count", 32'(count), 32'd0);
    chk("empty_rd_empty", 32'(empty), 32'd1);

    // Single frame round trip
    nr0 = nreads;
    send(8'h41, 1'b0, 1'b0);
    chk("t1_reads_once", 32'(nreads - nr0), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_empty", 32'(empty), 32'd0);
    pop("t1");
    chk("t1_empty_after", 32'(empty), 32'd1);
    chk("t1_rdata_after", 32'(rd_data), 32'h00);

    // rx_rdy held long after reads: one capture only
    nr0 = nreads;
    send(8'h55, 1'b0, 1'b0, 10);
    chk("hold_reads_once", 32'(nreads - nr0), 32'd1);
    chk("hold_count", 32'(count), 32'd1);
    pop("hold");

    // Table of pushes/pops, including push+pop at count 5 and error flags
    for (int i = 0; i < 12; i++) begin
      if (vt[i].push && vt[i].pop) both(vt[i].d, vt[i].pe, vt[i].fe);
      else if (vt[i].push)         send(vt[i].d, vt[i].pe, vt[i].fe);
      else                         pop("vec");
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_count));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].exp_count == 0));
    end
    pop("vec_last");
    chk("vec_drained", 32'(empty), 32'd1);

    // Fill, stall on full, pop releases the stalled frame a cycle later
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full",  32'(full),  32'd1);
    rx_data = 8'h10; parity_err = 1'b0; frame_err = 1'b0; rx_rdy = 1'b1;
    sb.push_back({2'b00, 8'h10});
    nr0 = nreads;
    cyc(3);
    chk("stall_no_reads", 32'(nreads - nr0), 32'd0);
    chk("stall_ovf",  32'(ovf),  32'd1);
    chk("stall_full", 32'(full), 32'd1);
    pop("stall_pop");
    chk("stall_pop_count", 32'(count), 32'd15);
    chk("stall_pop_reads", 32'(reads), 32'd0);
    cyc();
    chk("stall_wr_reads", 32'(reads), 32'd1);
    chk("stall_wr_count", 32'(count), 32'd16);
    rx_rdy = 1'b0;
    cyc();
    for (int i = 0; i < 16; i++) pop($sformatf("wrap%0d", i));
    chk("wrap_empty", 32'(empty), 32'd1);

    // ovf clear, then set-wins over clear
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0, 1'b0);
    rx_data = 8'h30; rx_rdy = 1'b1;
    cyc();
    chk("ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    cyc();
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    rx_rdy = 1'b0;
    cyc();
    chk("ovf_clr_alone", 32'(ovf), 32'd0);
    ovf_clr = 1'b0;

    // Reset asserted while in WAIT with count=3
    rst = 1'b0; cyc(); rst = 1'b1; sb.delete();
    send(8'h61, 1'b0, 1'b0);
    send(8'h62, 1'b0, 1'b0);
    begin
      bit got = 0;
      rx_data = 8'h63; rx_rdy = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
        cyc();
        if (reads === 1'b1) got = 1;
      end
      chk("wait_got_reads", 32'(got), 32'd1);
    end
    cyc();
    chk("wait_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    #2 rst = 1'b1;
    sb.delete();
    rx_data = 8'h70;
    sb.push_back({2'b00, 8'h70});
    cyc();
    chk("post_rst_reads", 32'(reads), 32'd1);
    chk("post_rst_count", 32'(count), 32'd1);
    rx_rdy = 1'b0;
    cyc();

`ifdef UART_RX_FIFO_THRESH_EN
    thresh = 5'd4;
`endif
    send(8'h71, 1'b0, 1'b0);
    send(8'h72, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_THRESH_EN
    chk("irq_below", 32'(rx_irq), 32'd0);
`endif
    send(8'h73, 1'b0, 1'b0);
    chk("thr_count", 32'(count), 32'd4);
`ifdef UART_RX_FIFO_THRESH_EN
    chk("irq_at_4", 32'(rx_irq), 32'd1);
`endif
    pop("post_rst_head");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
